me_pe_array_p: RTL and testbench

ME_PE_ARRAY_P -- requirements
Module: me_pe_array_p

---
 rtl/me_pkg.sv | 22 ++
 rtl/me_pe_array_p_if.sv | 38 +++
 rtl/me_cur_loader.sv | 71 +++++++
 rtl/me_pe_array_p.sv | 142 ++++++++++++++
 tb/tb_me_pe_array_p.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation PE array: default geometry
// and the reference-plane opcode encoding.
package me_pkg;

   localparam int PIXEL_W_D = 8;
   localparam int ARRAY_W_D = 32;
   localparam int ARRAY_H_D = 32;
   localparam int IN_PIX_D  = 2;
   localparam int JUMP_D    = 8;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_DN1  = 3'd1,
      OP_UP1  = 3'd2,
      OP_DNJ  = 3'd3,
      OP_UPJ  = 3'd4,
      OP_LEFT = 3'd5,
      OP_LOAD = 3'd6,
      OP_RSVD = 3'd7
   } ref_op_t;

endpackage

// File: rtl/me_pe_array_p_if.sv
// Bus bundle for me_pe_array_p: current-block loader handshake, reference
// update inputs and the difference/SAD results.
interface me_pe_array_p_if
   import me_pkg::*;
#(
   parameter int PIXEL_W = PIXEL_W_D,
   parameter int ARRAY_W = ARRAY_W_D,
   parameter int ARRAY_H = ARRAY_H_D,
   parameter int IN_PIX  = IN_PIX_D,
   parameter int JUMP    = JUMP_D
) ();

   localparam int SAD_W = PIXEL_W + $clog2(ARRAY_W * ARRAY_H);

   logic                                cur_valid;
   logic                                cur_ready;
   logic [IN_PIX*PIXEL_W-1:0]           cur_data;
   logic                                cur_swap;
   logic                                cur_full;
   logic [2:0]                          ref_op;
   logic [ARRAY_W*PIXEL_W-1:0]          ref_row_in;
   logic [JUMP*ARRAY_W*PIXEL_W-1:0]     ref_blk_in;
   logic [ARRAY_H*PIXEL_W-1:0]          ref_col_in;
   logic [ARRAY_W*ARRAY_H*PIXEL_W-1:0]  abs_out;
   logic [SAD_W-1:0]                    sad_out;
   logic                                sad_valid;

   modport master (
      output cur_valid, cur_data, cur_swap, ref_op, ref_row_in, ref_blk_in, ref_col_in,
      input  cur_ready, cur_full, abs_out, sad_out, sad_valid
   );

   modport slave (
      input  cur_valid, cur_data, cur_swap, ref_op, ref_row_in, ref_blk_in, ref_col_in,
      output cur_ready, cur_full, abs_out, sad_out, sad_valid
   );

endinterface

// File: rtl/me_cur_loader.sv
// Current-block loader: packs IN_PIX-pixel beats into rows, counts rows and
// flags when the shadow plane holds a full block. Needs at least two beats per row.
module me_cur_loader
   import me_pkg::*;
#(
   parameter int PIXEL_W = PIXEL_W_D,
   parameter int ARRAY_W = ARRAY_W_D,
   parameter int ARRAY_H = ARRAY_H_D,
   parameter int IN_PIX  = IN_PIX_D
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cur_valid,
   input  logic [IN_PIX*PIXEL_W-1:0]  cur_data,
   input  logic                       cur_swap,
   output logic                       cur_ready,
   output logic                       cur_full,
   output logic                       row_push,
   output logic [ARRAY_W*PIXEL_W-1:0] row_data,
   output logic                       swap_fire
);

   localparam int BEATS     = ARRAY_W / IN_PIX;
   localparam int SLICE_W   = IN_PIX * PIXEL_W;
   localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ROW_BITS  = (ARRAY_H > 1) ? $clog2(ARRAY_H) : 1;
   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
   localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ARRAY_H - 1);

   logic [BEAT_BITS-1:0]         beat_cnt;
   logic [ROW_BITS-1:0]          row_cnt;
   logic [(BEATS-1)*SLICE_W-1:0] row_buf;
   logic                         accept;

   assign cur_ready = !cur_full;
   assign accept    = cur_valid && cur_ready;
   assign row_push  = accept && (beat_cnt == LAST_BEAT);
   assign swap_fire = cur_swap && cur_full;

   // The final beat of a row bypasses the buffer so the row lands in the
   // shadow plane on the same edge that accepts it.
   assign row_data = {cur_data, row_buf};

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         row_cnt  <= '0;
         row_buf  <= '0;
         cur_full <= 1'b0;
      end else begin
         if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
               beat_cnt <= '0;
               if (row_cnt == LAST_ROW) begin
                  row_cnt  <= '0;
                  cur_full <= 1'b1;
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end else begin
               row_buf[beat_cnt*SLICE_W +: SLICE_W] <= cur_data;
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
         if (swap_fire) begin
            cur_full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/me_pe_array_p.sv
// PE array for block-matching motion estimation: double-buffered current
// block, shiftable reference window, per-PE absolute difference and SAD.
module me_pe_array_p
   import me_pkg::*;
#(
   parameter int PIXEL_W = PIXEL_W_D,
   parameter int ARRAY_W = ARRAY_W_D,
   parameter int ARRAY_H = ARRAY_H_D,
   parameter int IN_PIX  = IN_PIX_D,
   parameter int JUMP    = JUMP_D
) (
   input  logic            clk,
   input  logic            rst,
   me_pe_array_p_if.slave  bus
);

   localparam int SAD_W = PIXEL_W + $clog2(ARRAY_W * ARRAY_H);
   localparam int ROW_W = ARRAY_W * PIXEL_W;

   logic [ARRAY_H-1:0][ARRAY_W-1:0][PIXEL_W-1:0] shadow_q;
   logic [ARRAY_H-1:0][ARRAY_W-1:0][PIXEL_W-1:0] active_q;
   logic [ARRAY_H-1:0][ARRAY_W-1:0][PIXEL_W-1:0] ref_q;
   logic [ARRAY_H-1:0][ARRAY_W-1:0][PIXEL_W-1:0] abs_q;
   logic [SAD_W-1:0] sad_q;
   logic [SAD_W-1:0] sad_sum;
   logic [1:0]       ev_q;
   logic             sad_valid_q;
   logic             row_push;
   logic [ROW_W-1:0] row_data;
   logic             swap_fire;
   logic             plane_event;
   ref_op_t          op;

   me_cur_loader #(
      .PIXEL_W (PIXEL_W),
      .ARRAY_W (ARRAY_W),
      .ARRAY_H (ARRAY_H),
      .IN_PIX  (IN_PIX)
   ) u_loader (
      .clk       (clk),
      .rst       (rst),
      .cur_valid (bus.cur_valid),
      .cur_data  (bus.cur_data),
      .cur_swap  (bus.cur_swap),
      .cur_ready (bus.cur_ready),
      .cur_full  (bus.cur_full),
      .row_push  (row_push),
      .row_data  (row_data),
      .swap_fire (swap_fire)
   );

   assign op          = ref_op_t'(bus.ref_op);
   assign plane_event = ((op != OP_HOLD) && (op != OP_RSVD)) || swap_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (row_push) begin
            for (int r = 0; r < ARRAY_H - 1; r++) begin
               shadow_q[r] <= shadow_q[r + 1];
            end
            shadow_q[ARRAY_H-1] <= row_data;
         end
         if (swap_fire) begin
            active_q <= shadow_q;
         end
      end
   end

   // DN* slides the window downward in the frame, so stored rows move toward row 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_q <= '0;
      end else begin
         case (op)
            OP_DN1: begin
               for (int r = 0; r < ARRAY_H - 1; r++) ref_q[r] <= ref_q[r + 1];
               ref_q[ARRAY_H-1] <= bus.ref_row_in;
            end
            OP_UP1: begin
               for (int r = 1; r < ARRAY_H; r++) ref_q[r] <= ref_q[r - 1];
               ref_q[0] <= bus.ref_row_in;
            end
            OP_DNJ: begin
               for (int r = 0; r < ARRAY_H - JUMP; r++) ref_q[r] <= ref_q[r + JUMP];
               for (int k = 0; k < JUMP; k++) ref_q[ARRAY_H-JUMP+k] <= bus.ref_blk_in[k*ROW_W +: ROW_W];
            end
            OP_UPJ: begin
               for (int r = JUMP; r < ARRAY_H; r++) ref_q[r] <= ref_q[r - JUMP];
               for (int k = 0; k < JUMP; k++) ref_q[k] <= bus.ref_blk_in[k*ROW_W +: ROW_W];
            end
            OP_LEFT: begin
               for (int r = 0; r < ARRAY_H; r++) begin
                  for (int c = 0; c < ARRAY_W - 1; c++) ref_q[r][c] <= ref_q[r][c + 1];
                  ref_q[r][ARRAY_W-1] <= bus.ref_col_in[r*PIXEL_W +: PIXEL_W];
               end
            end
            OP_LOAD: begin
               for (int r = 0; r < ARRAY_H; r++) ref_q[r] <= bus.ref_blk_in[(r % JUMP)*ROW_W +: ROW_W];
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      sad_sum = '0;
      for (int r = 0; r < ARRAY_H; r++) begin
         for (int c = 0; c < ARRAY_W; c++) begin
            sad_sum = sad_sum + SAD_W'(abs_q[r][c]);
         end
      end
   end

   // The event pipe is two deep so sad_valid lines up with the SAD of the new position.
   always_ff @(posedge clk) begin
      if (rst) begin
         abs_q       <= '0;
         sad_q       <= '0;
         ev_q        <= '0;
         sad_valid_q <= 1'b0;
      end else begin
         for (int r = 0; r < ARRAY_H; r++) begin
            for (int c = 0; c < ARRAY_W; c++) begin
               abs_q[r][c] <= (active_q[r][c] > ref_q[r][c]) ? (active_q[r][c] - ref_q[r][c])
                                                             : (ref_q[r][c] - active_q[r][c]);
            end
         end
         sad_q       <= sad_sum;
         ev_q        <= {ev_q[0], plane_event};
         sad_valid_q <= ev_q[1];
      end
   end

   assign bus.abs_out   = abs_q;
   assign bus.sad_out   = sad_q;
   assign bus.sad_valid = sad_valid_q;

endmodule

// File: tb/tb_me_pe_array_p.sv
// Self-checking bench for me_pe_array_p: a 4x4 instance against a queue-based
// reference model, plus a 32x32 instance for the full-scale SAD.
module tb_me_pe_array_p;
   import me_pkg::*;

   localparam int P   = 8;
   localparam int SW  = 4;
   localparam int SH  = 4;
   localparam int SIN = 2;
   localparam int SJ  = 2;
   localparam int BW  = 32;
   localparam int BH  = 32;
   localparam int BJ  = 8;
   localparam int RW  = SW * P;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   me_pe_array_p_if #(.PIXEL_W(P), .ARRAY_W(SW), .ARRAY_H(SH), .IN_PIX(SIN), .JUMP(SJ)) s_if ();
   me_pe_array_p_if #(.PIXEL_W(P), .ARRAY_W(BW), .ARRAY_H(BH), .IN_PIX(SIN), .JUMP(BJ)) b_if ();

   me_pe_array_p #(.PIXEL_W(P), .ARRAY_W(SW), .ARRAY_H(SH), .IN_PIX(SIN), .JUMP(SJ)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (s_if)
   );

   me_pe_array_p #(.PIXEL_W(P), .ARRAY_W(BW), .ARRAY_H(BH), .IN_PIX(SIN), .JUMP(BJ)) u_big (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   // Model: reference window as a queue of rows (index 0 = top), active plane as rows.
   logic [RW-1:0]       mref[$];
   logic [RW-1:0]       mact[SH];
   logic [RW-1:0]       pend[SH];

   int                  bn;
   logic [2:0]          b_op[16];
   logic [RW-1:0]       b_row[16];
   logic [SJ*RW-1:0]    b_blk[16];
   logic [SH*P-1:0]     b_col[16];
   logic [SH*RW-1:0]    e_abs[16];
   int                  e_sad[16];
   bit                  e_val[16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [RW-1:0] row,
                                input logic [SJ*RW-1:0] blk, input logic [SH*P-1:0] col);
      s_if.ref_op     = op;
      s_if.ref_row_in = row;
      s_if.ref_blk_in = blk;
      s_if.ref_col_in = col;
   endtask

   task automatic modelReset();
      mref.delete();
      for (int r = 0; r < SH; r++) begin
         mref.push_back('0);
         mact[r] = '0;
      end
   endtask

   task automatic modelOp(input logic [2:0] op, input logic [RW-1:0] row,
                          input logic [SJ*RW-1:0] blk, input logic [SH*P-1:0] col);
      logic [RW-1:0] tmp;
      case (op)
         3'd1: begin void'(mref.pop_front()); mref.push_back(row); end
         3'd2: begin void'(mref.pop_back()); mref.push_front(row); end
         3'd3: begin
            for (int k = 0; k < SJ; k++) void'(mref.pop_front());
            for (int k = 0; k < SJ; k++) mref.push_back(blk[k*RW +: RW]);
         end
         3'd4: begin
            for (int k = 0; k < SJ; k++) void'(mref.pop_back());
            for (int k = SJ - 1; k >= 0; k--) mref.push_front(blk[k*RW +: RW]);
         end
         3'd5: begin
            for (int r = 0; r < SH; r++) begin
               tmp = mref[r];
               mref[r] = {col[r*P +: P], tmp[RW-1:P]};
            end
         end
         3'd6: begin
            for (int r = 0; r < SH; r++) mref[r] = blk[(r % SJ)*RW +: RW];
         end
         default: begin end
      endcase
   endtask

   task automatic modelAbs(output logic [SH*RW-1:0] a, output int s);
      logic [RW-1:0] rr;
      logic [RW-1:0] aa;
      int x, y, d;
      a = '0;
      s = 0;
      for (int r = 0; r < SH; r++) begin
         rr = mref[r];
         aa = mact[r];
         for (int c = 0; c < SW; c++) begin
            x = int'(aa[c*P +: P]);
            y = int'(rr[c*P +: P]);
            d = (x > y) ? x - y : y - x;
            a[(r*SW + c)*P +: P] = P'(d);
            s += d;
         end
      end
   endtask

   task automatic sendBeat(input logic [SIN*P-1:0] d);
      int n = 0;
      s_if.cur_valid = 1'b1;
      s_if.cur_data  = d;
      while (s_if.cur_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) checkOutput("beat ready timeout", 128'(s_if.cur_ready), 128'd1);
      tick();
      s_if.cur_valid = 1'b0;
   endtask

   task automatic loadSmall(input bit hold_extra);
      for (int r = 0; r < SH; r++) begin
         for (int b = 0; b < SW / SIN; b++) begin
            if (r == SH - 1 && b == SW / SIN - 1)
               checkOutput("cur_full before last beat", 128'(s_if.cur_full), 128'd0);
            sendBeat(pend[r][b*SIN*P +: SIN*P]);
         end
      end
      checkOutput("cur_full after block", 128'(s_if.cur_full), 128'd1);
      checkOutput("cur_ready after block", 128'(s_if.cur_ready), 128'd0);
      if (hold_extra) begin
         s_if.cur_valid = 1'b1;
         s_if.cur_data  = 16'hABCD;
         for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("extra beat held", 128'(s_if.cur_ready), 128'd0);
         end
         s_if.cur_valid = 1'b0;
      end
   endtask

   task automatic swapSmall();
      logic [SH*RW-1:0] ea;
      int es;
      s_if.cur_swap = 1'b1;
      tick();
      s_if.cur_swap = 1'b0;
      checkOutput("swap clears cur_full", 128'(s_if.cur_full), 128'd0);
      for (int r = 0; r < SH; r++) mact[r] = pend[r];
      modelAbs(ea, es);
      tick();
      checkOutput("swap abs_out", s_if.abs_out, ea);
      checkOutput("swap sad_valid early", 128'(s_if.sad_valid), 128'd0);
      tick();
      checkOutput("swap sad_valid", 128'(s_if.sad_valid), 128'd1);
      checkOutput("swap sad_out", 128'(s_if.sad_out), 128'(es));
      tick();
      checkOutput("swap sad_valid single", 128'(s_if.sad_valid), 128'd0);
   endtask

   task automatic runBurst();
      int n;
      b_op[bn] = 3'd0; b_op[bn+1] = 3'd0;
      b_row[bn] = '0;  b_row[bn+1] = '0;
      b_blk[bn] = '0;  b_blk[bn+1] = '0;
      b_col[bn] = '0;  b_col[bn+1] = '0;
      n = bn + 2;
      for (int t = 0; t <= n; t++) begin
         if (t < n) begin
            applyStimulus(b_op[t], b_row[t], b_blk[t], b_col[t]);
            modelOp(b_op[t], b_row[t], b_blk[t], b_col[t]);
            modelAbs(e_abs[t], e_sad[t]);
            e_val[t] = (b_op[t] >= 3'd1) && (b_op[t] <= 3'd6);
         end else begin
            applyStimulus(3'd0, '0, '0, '0);
         end
         tick();
         if (t >= 1)
            checkOutput($sformatf("abs_out op%0d", t - 1), s_if.abs_out, e_abs[t-1]);
         if (t >= 2) begin
            checkOutput($sformatf("sad_valid op%0d", t - 2), 128'(s_if.sad_valid), 128'(e_val[t-2]));
            checkOutput($sformatf("sad_out op%0d", t - 2), 128'(s_if.sad_out), 128'(e_sad[t-2]));
         end
      end
   endtask

   initial begin
      logic [SH*RW-1:0] ea;
      int es;
      int n;

      rst = 1'b1;
      s_if.cur_valid = 1'b0; s_if.cur_data = '0; s_if.cur_swap = 1'b0;
      applyStimulus(3'd0, '0, '0, '0);
      b_if.cur_valid = 1'b0; b_if.cur_data = '0; b_if.cur_swap = 1'b0;
      b_if.ref_op = 3'd0; b_if.ref_row_in = '0; b_if.ref_blk_in = '0; b_if.ref_col_in = '0;
      modelReset();
      tick();
      tick();
      rst = 1'b0;
      tick();
      $display("[TB] reset state");
      checkOutput("reset cur_ready", 128'(s_if.cur_ready), 128'd1);
      checkOutput("reset cur_full", 128'(s_if.cur_full), 128'd0);
      checkOutput("reset abs_out", s_if.abs_out, 128'd0);
      checkOutput("reset sad_out", 128'(s_if.sad_out), 128'd0);
      checkOutput("reset sad_valid", 128'(s_if.sad_valid), 128'd0);

      $display("[TB] reset during partial load with an op in flight");
      for (int i = 0; i < 5; i++) sendBeat(16'($urandom));
      applyStimulus(OP_DN1, RW'($urandom), '0, '0);
      tick();
      applyStimulus(3'd0, '0, '0, '0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      modelReset();
      tick();
      checkOutput("mid reset sad_valid", 128'(s_if.sad_valid), 128'd0);
      checkOutput("mid reset abs_out", s_if.abs_out, 128'd0);
      checkOutput("mid reset sad_out", 128'(s_if.sad_out), 128'd0);
      checkOutput("mid reset cur_ready", 128'(s_if.cur_ready), 128'd1);
      checkOutput("mid reset cur_full", 128'(s_if.cur_full), 128'd0);

      $display("[TB] ramp block load and swap");
      for (int r = 0; r < SH; r++)
         for (int c = 0; c < SW; c++) pend[r][c*P +: P] = P'(r*SW + c + 1);
      loadSmall(1'b1);
      swapSmall();

      $display("[TB] constant planes");
      for (int r = 0; r < SH; r++) pend[r] = {SW{8'h0A}};
      loadSmall(1'b0);
      swapSmall();
      bn = 1;
      b_op[0] = OP_LOAD; b_row[0] = '0; b_blk[0] = {SJ*SW{8'h07}}; b_col[0] = '0;
      runBurst();
      checkOutput("load sad 48", 128'(s_if.sad_out), 128'd48);
      b_op[0] = OP_DN1; b_row[0] = {SW{8'h0D}}; b_blk[0] = '0; b_col[0] = '0;
      runBurst();
      checkOutput("dn1 sad 48", 128'(s_if.sad_out), 128'd48);

      $display("[TB] swap without a full block");
      modelAbs(ea, es);
      s_if.cur_swap = 1'b1;
      tick();
      s_if.cur_swap = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("idle swap sad_valid", 128'(s_if.sad_valid), 128'd0);
      end
      checkOutput("idle swap abs_out", s_if.abs_out, ea);

      $display("[TB] jump, up and left ops back to back");
      for (int r = 0; r < SH; r++) pend[r] = RW'($urandom);
      loadSmall(1'b0);
      swapSmall();
      bn = 4;
      b_op[0] = OP_DNJ; b_op[1] = OP_UPJ; b_op[2] = OP_UP1; b_op[3] = OP_LEFT;
      for (int i = 0; i < 4; i++) begin
         b_row[i] = RW'($urandom);
         b_blk[i] = {$urandom, $urandom};
         b_col[i] = RW'($urandom);
      end
      runBurst();

      $display("[TB] random op bursts");
      for (int k = 0; k < 2; k++) begin
         bn = 12;
         for (int i = 0; i < bn; i++) begin
            b_op[i]  = 3'($urandom_range(0, 7));
            b_row[i] = RW'($urandom);
            b_blk[i] = {$urandom, $urandom};
            b_col[i] = RW'($urandom);
         end
         runBurst();
      end

      $display("[TB] full-scale saturation");
      b_if.cur_valid = 1'b1;
      b_if.cur_data  = '1;
      n = 0;
      while (b_if.cur_full !== 1'b1 && n < 600) begin
         tick();
         n++;
      end
      b_if.cur_valid = 1'b0;
      checkOutput("big cur_full", 128'(b_if.cur_full), 128'd1);
      b_if.cur_swap = 1'b1;
      tick();
      b_if.cur_swap = 1'b0;
      tick();
      tick();
      checkOutput("big sad_valid", 128'(b_if.sad_valid), 128'd1);
      checkOutput("big sad_out", 128'(b_if.sad_out), 128'(BW * BH * 255));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
